id_stage: RTL and testbench
===========================

// Module: id_stage
// PURPOSE
//  Instruction-decode stage of the single-cycle MIPS core: 32x32 register file plus immediate extender.
//  Reads the rs and rt registers named by Ins and extends Ins[15:0] to 32 bits.
//  Writes Wdata back to the destination register decoded from the same Ins.
//  Sits between instruction fetch (Ins) and execute/writeback (Wdata).
// PARAMETERS
//  none; widths fixed at 32-bit data, 5-bit register address, 32 registers
// PORTS
//  CLK     in   1   clock; register-file writes on rising edge
//  RST     in   1   reset, asynchronous, active-high; clears all registers
//  Ins     in   32  current instruction
//  Wdata   in   32  writeback data for the destination register of Ins
//  Rdata1  out  32  GPR[Ins[25:21]] (rs), combinational
//  Rdata2  out  32  GPR[Ins[20:16]] (rt), combinational
//  Ed32    out  32  extended Ins[15:0], combinational
// BEHAVIOUR
//  - Reset: while RST=1, all 32 registers are 0, so Rdata1=Rdata2=0. Ed32 stays combinational from Ins. No writes occur during reset.
//  - Reads: asynchronous, zero latency. GPR0 always reads 0.
//  - Write decode from opcode Ins[31:26]:
//    0x00 R-type -> dest rd=Ins[15:11], except funct 0x08 (jr), which does not write.
//    0x08-0x0F (addi..lui) -> dest rt.
//    0x20,0x21,0x23,0x24,0x25 loads -> dest rt.
//    0x03 jal -> dest 31.
//    All others do not write: sw/sb/sh, beq/bne, j, and unknown opcodes.
//  - Write: at posedge CLK with RST=0, if write enabled and dest!=0, GPR[dest] <= Wdata. Writes to 0 are dropped.
//  - Read-during-write to the same register: the read shows the old value until the edge, then the new value.
//  - Ed32 = {{16{Ins[15]}}, Ins[15:0]}, sign extension, for all opcodes.
//  - Reset asserted mid-operation clears every register immediately, regardless of CLK.
// CONFIGURATION
//  ID_ZERO_EXT_LOGIC_EN:
//    defined: for andi(0x0C), ori(0x0D), xori(0x0E), Ed32 = {16'h0, Ins[15:0]}; all other opcodes sign-extend.
//    undefined: all opcodes sign-extend.
// STRUCTURE
//  - Shared package (mips_pkg): opcode/funct localparams (OP_RTYPE, OP_ADDI, OP_ORI, OP_LW, OP_SW, OP_BEQ, OP_J, OP_JAL, FN_JR), REG_RA=31, data/address widths.
//  - Sub-module id_regfile: 2 async read ports, 1 sync write port, async reset, GPR0 hardwired to 0.
//  - id_stage holds the write-enable/destination decoder and the extender.
// TESTING
//  1. RST=1 for 20 units, then release -> Rdata1=Rdata2=0 for every rs/rt.
//  2. Ins=0x34010005, Wdata=5, one edge; then Ins=0x34020003, Wdata=3, one edge -> GPR1=5, GPR2=3.
//     Ed32=0x00000005, then 0x00000003.
//  3. Ins=0x00221820 (add $3,$1,$2) -> Rdata1=5, Rdata2=3. Wdata=8, one edge -> GPR3=8.
//  4. Ins=0x20220064 (addi), Wdata=0x69 -> Ed32=0x00000064; after the edge GPR2=0x69.
//     Ins=0x8C220004 (lw), Wdata=0x12345678 -> GPR2=0x12345678 after the edge.
//  5. No-write opcodes:
//     Ins=0xAC220008 (sw), Ins=0x10220010 (beq), Ins=0x08000400 (j), each with Wdata=0 -> GPR1/GPR2 unchanged (5, 0x12345678).
//     beq: Ed32=0x00000010.
//  6. Edge cases:
//     Ins=0x2000FFFC (addi $0) with Wdata=0xDEAD -> GPR0 still reads 0; Ed32=0xFFFFFFFC.
//     Ins=0x3401FFFF (ori) -> Ed32=0x0000FFFF with ID_ZERO_EXT_LOGIC_EN defined, 0xFFFFFFFF without it.
//     RST pulse mid-run -> all registers read 0 immediately.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS definitions: opcode/funct encodings, register indices and datapath widths.
package mips_pkg;

  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;
  localparam int NUM_REGS = 32;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LB    = 6'h20;
  localparam logic [5:0] OP_LH    = 6'h21;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_LBU   = 6'h24;
  localparam logic [5:0] OP_LHU   = 6'h25;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_JR    = 6'h08;

  localparam logic [ADDR_W-1:0] REG_ZERO = 5'd0;
  localparam logic [ADDR_W-1:0] REG_RA   = 5'd31;

endpackage

// File: rtl/id_regfile.sv
// 32x32 general-purpose register file: two asynchronous read ports, one synchronous
// write port, asynchronous active-high clear; register 0 always reads as zero.
module id_regfile
  import mips_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] ra1,
  input  logic [ADDR_W-1:0] ra2,
  input  logic              we,
  input  logic [ADDR_W-1:0] wa,
  input  logic [DATA_W-1:0] wd,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2
);

  logic [DATA_W-1:0] gpr [NUM_REGS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        gpr[i] <= '0;
      end
    end else if (we && (wa != REG_ZERO)) begin
      gpr[wa] <= wd;
    end
  end

  // Reads are unregistered, so a same-cycle write only becomes visible after the edge.
  assign rd1 = (ra1 == REG_ZERO) ? '0 : gpr[ra1];
  assign rd2 = (ra2 == REG_ZERO) ? '0 : gpr[ra2];

endmodule

// File: rtl/id_stage.sv
// Instruction-decode stage: register file, writeback destination decoder and immediate extender.
// Optional build macro ID_ZERO_EXT_LOGIC_EN zero-extends the immediate for andi/ori/xori.
module id_stage
  import mips_pkg::*;
(
  input  logic              CLK,
  input  logic              RST,
  input  logic [DATA_W-1:0] Ins,
  input  logic [DATA_W-1:0] Wdata,
  output logic [DATA_W-1:0] Rdata1,
  output logic [DATA_W-1:0] Rdata2,
  output logic [DATA_W-1:0] Ed32
);

  logic [5:0]        opcode;
  logic [5:0]        funct;
  logic [ADDR_W-1:0] rs;
  logic [ADDR_W-1:0] rt;
  logic [ADDR_W-1:0] rd;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_dest;
  logic              zero_ext;

  assign opcode = Ins[31:26];
  assign rs     = Ins[25:21];
  assign rt     = Ins[20:16];
  assign rd     = Ins[15:11];
  assign funct  = Ins[5:0];

  always_comb begin
    wr_en   = 1'b0;
    wr_dest = rt;
    if (opcode == OP_RTYPE) begin
      wr_dest = rd;
      wr_en   = (funct != FN_JR);
    end else if (opcode == OP_JAL) begin
      wr_dest = REG_RA;
      wr_en   = 1'b1;
    end else if ((opcode >= OP_ADDI) && (opcode <= OP_LUI)) begin
      wr_en   = 1'b1;
    end else if (opcode inside {OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU}) begin
      wr_en   = 1'b1;
    end
  end

  always_comb begin
`ifdef ID_ZERO_EXT_LOGIC_EN
    zero_ext = (opcode inside {OP_ANDI, OP_ORI, OP_XORI});
`else
    zero_ext = 1'b0;
`endif
    Ed32 = zero_ext ? {16'h0000, Ins[15:0]} : {{16{Ins[15]}}, Ins[15:0]};
  end

  id_regfile u_regfile (
    .clk (CLK),
    .rst (RST),
    .ra1 (rs),
    .ra2 (rt),
    .we  (wr_en),
    .wa  (wr_dest),
    .wd  (Wdata),
    .rd1 (Rdata1),
    .rd2 (Rdata2)
  );

endmodule

// File: tb/tb_id_stage.sv
// Self-checking bench for id_stage: reference register model, expected-value queue,
// directed decode/extend vectors, reset behaviour and randomized instruction mix.
module tb_id_stage;

  logic        CLK = 1'b0;
  logic        RST;
  logic [31:0] Ins;
  logic [31:0] Wdata;
  logic [31:0] Rdata1;
  logic [31:0] Rdata2;
  logic [31:0] Ed32;

  logic [31:0] model_gpr [32];
  logic [31:0] exp_q [$];
  int          vectors     = 0;
  int          miscompares = 0;

  localparam logic [31:0] PARK_INS = 32'hAC00_0000;  // sw $0,0($0): no writeback

  id_stage dut (
    .CLK    (CLK),
    .RST    (RST),
    .Ins    (Ins),
    .Wdata  (Wdata),
    .Rdata1 (Rdata1),
    .Rdata2 (Rdata2),
    .Ed32   (Ed32)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s ins=%h got=%h exp=%h t=%0t", tag, Ins, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_ext(input logic [31:0] ins);
    logic [5:0] op;
    op = ins[31:26];
`ifdef ID_ZERO_EXT_LOGIC_EN
    if (op == 6'h0C || op == 6'h0D || op == 6'h0E) return {16'h0000, ins[15:0]};
`endif
    return ins[15] ? {16'hFFFF, ins[15:0]} : {16'h0000, ins[15:0]};
  endfunction

  // Returns {write_enable, destination}.
  function automatic logic [5:0] model_wr(input logic [31:0] ins);
    case (ins[31:26])
      6'h00: return (ins[5:0] == 6'h08) ? 6'd0 : {1'b1, ins[15:11]};
      6'h03: return {1'b1, 5'd31};
      6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F,
      6'h20, 6'h21, 6'h23, 6'h24, 6'h25: return {1'b1, ins[20:16]};
      default: return 6'd0;
    endcase
  endfunction

  task automatic push_expected();
    exp_q.push_back(model_gpr[Ins[25:21]]);
    exp_q.push_back(model_gpr[Ins[20:16]]);
    exp_q.push_back(model_ext(Ins));
  endtask

  task automatic compare_outputs();
    if (exp_q.size() < 3) begin
      check("scoreboard_underflow", 32'(exp_q.size()), 32'd3);
    end else begin
      check("rdata1", Rdata1, exp_q.pop_front());
      check("rdata2", Rdata2, exp_q.pop_front());
      check("ed32",   Ed32,   exp_q.pop_front());
    end
  endtask

  task automatic read_only(input logic [31:0] ins);
    @(negedge CLK);
    Ins   = ins;
    Wdata = $urandom;
    #1;
    push_expected();
    compare_outputs();
  endtask

  // Checks old values before the edge, applies the write to the model, checks after the edge.
  task automatic apply(input logic [31:0] ins, input logic [31:0] wdata);
    logic [5:0] w;
    @(negedge CLK);
    Ins   = ins;
    Wdata = wdata;
    #1;
    push_expected();
    compare_outputs();
    @(posedge CLK);
    #1;
    w = model_wr(ins);
    if (!RST && w[5] && (w[4:0] != 5'd0)) model_gpr[w[4:0]] = wdata;
    push_expected();
    compare_outputs();
    Ins = PARK_INS;
  endtask

  task automatic model_clear();
    for (int i = 0; i < 32; i++) model_gpr[i] = 32'h0;
  endtask

  initial begin
    logic [5:0]  op_tab [16];
    logic [5:0]  op;
    logic [31:0] ins;

    op_tab = '{6'h00, 6'h00, 6'h08, 6'h09, 6'h0C, 6'h0D, 6'h0E, 6'h0F,
               6'h20, 6'h23, 6'h25, 6'h03, 6'h2B, 6'h04, 6'h02, 6'h3F};
    model_clear();
    RST   = 1'b1;
    Ins   = PARK_INS;
    Wdata = 32'h0;
    #20;
    RST = 1'b0;

    // Every register reads zero after reset.
    for (int i = 0; i < 32; i++) begin
      ins = {6'h2B, 5'(i), 5'(31 - i), 16'h0000};
      read_only(ins);
    end

    apply(32'h3401_0005, 32'h0000_0005);   // ori $1,$0,5
    apply(32'h3402_0003, 32'h0000_0003);   // ori $2,$0,3
    apply(32'h0022_1820, 32'h0000_0008);   // add $3,$1,$2
    read_only(32'hAC61_0000);              // read $3,$1
    apply(32'h2022_0064, 32'h0000_0069);   // addi $2,$1,100
    apply(32'h8C22_0004, 32'h1234_5678);   // lw $2,4($1)
    apply(32'hAC22_0008, 32'h0000_0000);   // sw
    apply(32'h1022_0010, 32'h0000_0000);   // beq
    apply(32'h0800_0400, 32'h0000_0000);   // j
    apply(32'h0060_0008, 32'hBAD0_0001);   // jr $3: no write
    apply(32'h0C00_0010, 32'h0040_0020);   // jal -> $31
    apply(32'h2000_FFFC, 32'h0000_DEAD);   // addi $0: dropped
    apply(32'h3401_FFFF, 32'h0000_FFFF);   // ori: extension mode under test
    apply(32'h0023_2020, 32'hCAFE_F00D);   // add $4,$1,$3
    read_only(32'hAC9F_0000);              // read $4,$31

    // Asynchronous reset mid-run, away from any rising edge.
    @(negedge CLK);
    Ins = 32'hAC22_0000;
    #2;
    RST = 1'b1;
    #1;
    model_clear();
    push_expected();
    compare_outputs();
    // A write instruction held across an edge during reset must not land.
    apply(32'h3401_1234, 32'h5555_AAAA);
    @(negedge CLK);
    RST = 1'b0;
    read_only(32'hAC01_0000);

    // Randomized instruction mix against the reference model.
    for (int n = 0; n < 60; n++) begin
      op  = op_tab[$urandom_range(0, 15)];
      ins = {op, 26'($urandom)};
      if (op == 6'h00 && ($urandom_range(0, 3) == 0)) ins[5:0] = 6'h08;
      apply(ins, $urandom);
    end

    for (int i = 0; i < 32; i += 2) begin
      ins = {6'h2B, 5'(i), 5'(i + 1), 16'h0000};
      read_only(ins);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
